pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB register banks).
- Detects load-use hazards, resolves taken-branch flushes, and freezes the pipeline while data memory is busy.
- Drives per-stage enables and the ID/EX bubble (zeroes the 10-bit control bus plus ALUOp) that the stage registers consume.

Parameters:
- LOAD_STALL, default 1: bubble cycles inserted per load-use hazard (1..4).
- FLUSH_DEPTH, default 1: cycles ifid_flush is held after a taken branch (1..4).
- REG_W, default 5: register index width.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: synchronous, active-low; 0 = reset.
- id_rn, in, REG_W: source Rn of the instruction in ID.
- id_rm, in, REG_W: source Rm/Rd (Reg2Loc-selected) of the instruction in ID.
- id_uses_rn, in, 1: ID instruction reads Rn.
- id_uses_rm, in, 1: ID instruction reads the second source.
- ex_rd, in, REG_W: destination register in EX.
- ex_memread, in, 1: MemRead of the EX instruction.
- ex_regwrite, in, 1: RegWrite of the EX instruction.
- br_taken_ex, in, 1: branch resolved taken in EX.
- dmem_busy, in, 1: data memory not ready this cycle.
- pc_en, out, 1: PC load enable.
- ifid_en, out, 1: IF/ID register enable.
- ifid_flush, out, 1: IF/ID clear to NOP.
- idex_en, out, 1: ID/EX register enable.
- idex_bubble, out, 1: ID/EX loads all-zero control.
- exmem_en, out, 1: EX/MEM register enable.
- memwb_en, out, 1: MEM/WB register enable.
- state, out, 2: current FSM state (for debug).

Behaviour:
- States: RUN=0, LSTALL=1, FLUSH=2, MWAIT=3. The FSM register and a 2-bit counter cnt update on the rising edge. Outputs are combinational from state and inputs.
- Hazard: haz = ex_memread & ex_regwrite & (ex_rd != 31) & ((id_uses_rn & id_rn == ex_rd) | (id_uses_rm & id_rm == ex_rd)). X31 (XZR) never creates a hazard.
- Default outputs: all enables 1, ifid_flush 0, idex_bubble 0.
- RUN, checked in priority order dmem_busy > br_taken_ex > haz:
  - dmem_busy: all five enables 0, no flush, no bubble; next state MWAIT.
  - br_taken_ex: pc_en 1, ifid_flush 1, idex_bubble 1. If FLUSH_DEPTH > 1, next state FLUSH with cnt = FLUSH_DEPTH-2; otherwise stay in RUN.
  - haz: pc_en 0, ifid_en 0, idex_bubble 1. If LOAD_STALL > 1, next state LSTALL with cnt = LOAD_STALL-2; otherwise stay in RUN.
- LSTALL: same outputs as the haz case. When cnt == 0, go to RUN; otherwise decrement cnt. dmem_busy preempts to MWAIT, and the remaining stall count is discarded.
- FLUSH: ifid_flush 1, idex_bubble 1, other enables 1. When cnt == 0, go to RUN; otherwise decrement. dmem_busy preempts to MWAIT.
- MWAIT: all enables 0. Leave for RUN on the first cycle dmem_busy == 0, and drive defaults in that cycle. A branch or load held in EX during the wait is re-evaluated in RUN, because EX is frozen.
- Simultaneous branch and haz: the branch wins. The load-use instruction is on the flushed path.
- Reset: while reset == 0, state = RUN and cnt = 0. Outputs are pc_en/ifid_en/idex_en/exmem_en/memwb_en = 0, ifid_flush = 1, idex_bubble = 1. A reset mid-stall or mid-flush aborts immediately. The first cycle after reset releases shows the default outputs.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles increments each cycle pc_en == 0 outside reset.
  - flush_cycles increments each cycle ifid_flush == 1 outside reset.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds the state enum (RUN, LSTALL, FLUSH, MWAIT), XZR = 5'd31, and REG_W.
- Sub-module load_use_detect holds the combinational haz compare. It is reusable by a future forwarding unit.

Test Plan:
- Load X3 in EX (ex_memread=1, ex_regwrite=1, ex_rd=3) with ID id_rn=3, id_uses_rn=1 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then defaults.
- Same stimulus with ex_rd=31, or with id_uses_rn=0 -> no stall.
- br_taken_ex=1 for 1 cycle with FLUSH_DEPTH=2 -> ifid_flush=1 and idex_bubble=1 for 2 cycles, state RUN→FLUSH→RUN.
- dmem_busy=1 for 3 cycles during an LSTALL with LOAD_STALL=3 -> all enables 0 for 3 cycles, then RUN with defaults.
- br_taken_ex and haz in the same cycle -> flush outputs with pc_en=1, no LSTALL entry.
- reset=0 asserted in the FLUSH state -> next cycle state=RUN, enables 0, ifid_flush=1. After release, defaults. With HAZARD_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared state encoding and register-file constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        MWAIT  = 2'd3
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-control bundle between the pipeline datapath (master) and pipe_hazard_ctrl (slave).
// Defining HAZARD_PERF_EN adds the stall_cycles/flush_cycles counters to the bundle.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W
);
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic [REG_W-1:0] ex_rd;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic             ex_memread;
    logic             ex_regwrite;
    logic             br_taken_ex;
    logic             dmem_busy;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic             exmem_en;
    logic             memwb_en;
    logic [1:0]       state;
`ifdef HAZARD_PERF_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_cycles;
`endif

    modport master (
`ifdef HAZARD_PERF_EN
        input  stall_cycles, flush_cycles,
`endif
        output id_rn, id_rm, ex_rd, id_uses_rn, id_uses_rm,
        output ex_memread, ex_regwrite, br_taken_ex, dmem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
        input  exmem_en, memwb_en, state
    );

    modport slave (
`ifdef HAZARD_PERF_EN
        output stall_cycles, flush_cycles,
`endif
        input  id_rn, id_rm, ex_rd, id_uses_rn, id_uses_rm,
        input  ex_memread, ex_regwrite, br_taken_ex, dmem_busy,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
        output exmem_en, memwb_en, state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the load in EX and the sources of the ID instruction.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    output logic             haz
);

    // XZR reads as zero, so a load targeting it never feeds a real value forward.
    assign haz = ex_memread & ex_regwrite & (ex_rd != REG_W'(XZR)) &
                 ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, dmem freezes.
// Optional HAZARD_PERF_EN macro adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL  = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int REG_W       = pipe_ctrl_pkg::REG_W
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] LS_INIT = 2'((LOAD_STALL  > 1) ? LOAD_STALL  - 2 : 0);
    localparam logic [1:0] FD_INIT = 2'((FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0);

    hz_state_e  cur_state;
    logic [1:0] cnt;
    logic       haz;

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .id_rn       (bus.id_rn),
        .id_rm       (bus.id_rm),
        .ex_rd       (bus.ex_rd),
        .id_uses_rn  (bus.id_uses_rn),
        .id_uses_rm  (bus.id_uses_rm),
        .ex_memread  (bus.ex_memread),
        .ex_regwrite (bus.ex_regwrite),
        .haz         (haz)
    );

    // cnt holds the extra stall/flush cycles still owed after the current one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= RUN;
            cnt       <= '0;
        end else begin
            case (cur_state)
                RUN: begin
                    if (bus.dmem_busy) begin
                        cur_state <= MWAIT;
                    end else if (bus.br_taken_ex) begin
                        if (FLUSH_DEPTH > 1) begin
                            cur_state <= FLUSH;
                            cnt       <= FD_INIT;
                        end
                    end else if (haz) begin
                        if (LOAD_STALL > 1) begin
                            cur_state <= LSTALL;
                            cnt       <= LS_INIT;
                        end
                    end
                end
                LSTALL, FLUSH: begin
                    if (bus.dmem_busy) begin
                        cur_state <= MWAIT;
                        cnt       <= '0;
                    end else if (cnt == 2'd0) begin
                        cur_state <= RUN;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                MWAIT: begin
                    if (!bus.dmem_busy) cur_state <= RUN;
                end
            endcase
        end
    end

    // A busy data memory freezes every stage regardless of state; the branch beats the load-use hazard.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!reset) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (bus.dmem_busy) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else begin
            case (cur_state)
                RUN: begin
                    if (bus.br_taken_ex) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (haz) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                LSTALL: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.state       = cur_state;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
            if (ifid_flush && (flush_cycles != 32'hFFFF_FFFF)) flush_cycles <= flush_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cycles;
    assign bus.flush_cycles = flush_cycles;
`endif

endmodule
